// File: rtl/lpc_i2s_tx.sv
// lpc_i2s_tx: sink for the lpc decoder's PHY sample port.
// Pulls decoded channel pairs over the phy_rd handshake, undoes FLAC stereo
// decorrelation, buffers {R,L} frames in a small FIFO and serialises them as
// standard I2S (16-bit slots, MSB first, 32 BCLK per frame).
// Optional feature: define LPC_I2S_HOLD_EN to repeat the last popped frame on
// underrun instead of sending silence.
module lpc_i2s_tx #(
  parameter int unsigned BCLK_HALF  = 65,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_rd_valid,
  output logic        phy_rd,
  input  logic [1:0]  phy_rd_chansgn,
  input  logic [16:0] phy_rd_data_chan0,
  input  logic [16:0] phy_rd_data_chan1,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sd,
  output logic [15:0] underrun_cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  // ---------------------------------------------------------------------------
  // Handshake and capture stage
  // ---------------------------------------------------------------------------
  logic        take;
  logic        cap_valid;
  logic [1:0]  cap_sgn;
  logic [16:0] cap_ch0;
  logic [16:0] cap_ch1;

  logic [AW:0]   occ;
  logic [AW+1:0] used;

  assign take = phy_rd & phy_rd_valid;

  // Pairs already committed (in FIFO, in the capture stage, or being strobed)
  assign used = {1'b0, occ}
              + {{(AW+1){1'b0}}, cap_valid}
              + {{(AW+1){1'b0}}, phy_rd};

  // Read strobe: single-cycle pulses, never back to back, only with room left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phy_rd <= 1'b0;
    end else begin
      phy_rd <= phy_rd_valid && !phy_rd && (used < (AW+2)'(FIFO_DEPTH));
    end
  end

  // Capture register loaded on each completed transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_sgn   <= '0;
      cap_ch0   <= '0;
      cap_ch1   <= '0;
    end else begin
      cap_valid <= take;
      if (take) begin
        cap_sgn <= phy_rd_chansgn;
        cap_ch0 <= phy_rd_data_chan0;
        cap_ch1 <= phy_rd_data_chan1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stereo reconstruction (17-bit arithmetic, low 16 bits kept)
  // ---------------------------------------------------------------------------
  logic [16:0] diff01;
  logic [16:0] sum01;
  logic [16:0] side_half;
  logic [16:0] mid_r;
  logic [16:0] mid_l;
  logic [15:0] rec_l;
  logic [15:0] rec_r;

  // Undo left/side, side/right and mid/side decorrelation
  always_comb begin
    diff01    = cap_ch0 - cap_ch1;
    sum01     = cap_ch0 + cap_ch1;
    side_half = {cap_ch1[16], cap_ch1[16:1]};
    mid_r     = cap_ch0 - side_half;
    mid_l     = mid_r + cap_ch1;
    rec_l     = cap_ch0[15:0];
    rec_r     = cap_ch1[15:0];
    unique case (cap_sgn)
      2'd0: begin
        rec_l = cap_ch0[15:0];
        rec_r = cap_ch1[15:0];
      end
      2'd1: begin
        rec_l = cap_ch0[15:0];
        rec_r = diff01[15:0];
      end
      2'd2: begin
        rec_l = sum01[15:0];
        rec_r = cap_ch1[15:0];
      end
      default: begin
        rec_l = mid_l[15:0];
        rec_r = mid_r[15:0];
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame FIFO, entries stored as {R,L}
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic          fifo_empty;
  logic [31:0]   head;

  logic          fall;
  logic [4:0]    fidx;
  logic          frame_start;

  assign fifo_empty  = (occ == '0);
  assign frame_start = fall && (fidx == 5'd0);
  assign do_push     = cap_valid;
  assign do_pop      = frame_start && !fifo_empty;
  assign head        = mem[rd_ptr];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {rec_r, rec_l};
    end
  end

  // Pointers and occupancy; push and pop in the same cycle cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bit clock divider
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div;
  logic          div_wrap;

  assign div_wrap = (div == DW'(BCLK_HALF - 1));
  assign fall     = div_wrap && i2s_bclk;

  // Toggle BCLK every BCLK_HALF core cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_wrap) begin
      div      <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div      <= div + DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Underrun fill frame
  // ---------------------------------------------------------------------------
  logic [31:0] fill_word;
  logic [31:0] load_word;

`ifdef LPC_I2S_HOLD_EN
  logic [31:0] last_word;

  // Remember the most recently popped frame for replay on underrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_word <= '0;
    end else if (do_pop) begin
      last_word <= {head[15:0], head[31:16]};
    end
  end

  assign fill_word = last_word;
`else
  assign fill_word = '0;
`endif

  // Shift order is {L,R}: left slot goes out first
  assign load_word = fifo_empty ? fill_word : {head[15:0], head[31:16]};

  // ---------------------------------------------------------------------------
  // Serializer: sd/lrck move only on BCLK falling edges
  // ---------------------------------------------------------------------------
  logic [31:0] shreg;

  // MSB of the frame is presented on the same edge that loads it, so the
  // shift register holds the remaining 31 bits left-aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fidx         <= '0;
      shreg        <= '0;
      i2s_sd       <= 1'b0;
      i2s_lrck     <= 1'b0;
      underrun_cnt <= '0;
    end else if (fall) begin
      fidx <= fidx + 5'd1;
      if (fidx == 5'd0) begin
        i2s_sd <= load_word[31];
        shreg  <= {load_word[30:0], 1'b0};
        if (fifo_empty && (underrun_cnt != 16'hFFFF)) begin
          underrun_cnt <= underrun_cnt + 16'd1;
        end
      end else begin
        i2s_sd <= shreg[31];
        shreg  <= {shreg[30:0], 1'b0};
      end
      if (fidx == 5'd15) begin
        i2s_lrck <= 1'b1;
      end else if (fidx == 5'd31) begin
        i2s_lrck <= 1'b0;
      end
    end
  end

endmodule
